cobs_rx_arbiter: RTL and testbench

COBS_RX_ARBITER -- requirements
Module: cobs_rx_arbiter

---
 rtl/cobs_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/cobs_rx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cobs_rx_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cobs_pkg.sv
`default_nettype none
// ============================================================================
// Package : cobs_pkg
// Brief   : Byte width, COBS delimiter and arbiter state encoding.
// Revision: 1.0
// ============================================================================
package cobs_pkg;

  localparam int DW = 8;

  localparam logic [DW-1:0] COBS_DELIM = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational pick of the first requester at or after ptr.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_any
);

  logic [CW:0] cand;

  // Scan NCH positions starting at ptr, wrapping at NCH (not at 2**CW).
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = {1'b0, ptr} + (CW+1)'(i);
      if (cand >= (CW+1)'(NCH)) begin
        cand = cand - (CW+1)'(NCH);
      end
      if (!gnt_any && req[cand[CW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[CW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cobs_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cobs_rx_arbiter
// Brief   : Shares one COBS decoder input among NCH channels, a frame per grant.
// Revision: 1.0
// ============================================================================
module cobs_rx_arbiter
  import cobs_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int TIMEOUT = 1024,
  localparam int CW      = $clog2(NCH),
  localparam int TW      = $clog2(TIMEOUT) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0][DW-1:0] s_data,
  input  logic [NCH-1:0]         s_valid,
  output logic [NCH-1:0]         s_ready,
  output logic [DW-1:0]          m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [CW-1:0]          m_chan,
  output logic                   m_last,
  output logic                   abort,
  output logic                   busy
);

  localparam logic [TW-1:0] TCNT_MAX = '1;
  localparam logic [TW-1:0] TCNT_HIT = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);

  state_e          state_q,   state_d;
  logic [CW-1:0]   gnt_q,     gnt_d;
  logic [CW-1:0]   rr_ptr_q,  rr_ptr_d;
  logic            seen_q,    seen_d;
  logic [TW-1:0]   tcnt_q,    tcnt_d;
  logic [DW-1:0]   m_data_q,  m_data_d;
  logic            m_valid_q, m_valid_d;
  logic [CW-1:0]   m_chan_q,  m_chan_d;
  logic            m_last_q,  m_last_d;
  logic            abort_q,   abort_d;

  logic [CW-1:0]   arb_idx;
  logic            arb_any;
  logic            slot_free;
  logic            g_valid;
  logic [DW-1:0]   g_data;
  logic            g_acc;
  logic            tmo_hit;

  rr_arbiter #(
    .NCH     (NCH)
  ) u_rr_arbiter (
    .req     (s_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign slot_free = !m_valid_q || m_ready;
  assign g_valid   = s_valid[gnt_q];
  assign g_data    = s_data[gnt_q];
  assign g_acc     = (state_q == ST_GRANT) && g_valid && slot_free;
  assign tmo_hit   = (tcnt_q >= TCNT_HIT);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    seen_d    = seen_q;
    tcnt_d    = tcnt_q;
    m_data_d  = m_data_q;
    m_chan_d  = m_chan_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q && !m_ready;
    abort_d   = 1'b0;
    s_ready   = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d    = arb_idx;
          rr_ptr_d = (arb_idx == LAST_CH) ? '0 : arb_idx + CW'(1);
          seen_d   = 1'b0;
          tcnt_d   = '0;
          state_d  = ST_GRANT;
        end
      end

      ST_GRANT: begin
        s_ready[gnt_q] = slot_free;
        if (g_acc) begin
          if (g_data != COBS_DELIM) begin
            m_data_d  = g_data;
            m_chan_d  = gnt_q;
            m_last_d  = 1'b0;
            m_valid_d = 1'b1;
            seen_d    = 1'b1;
            tcnt_d    = '0;
          end else if (seen_q) begin
            m_data_d  = COBS_DELIM;
            m_chan_d  = gnt_q;
            m_last_d  = 1'b1;
            m_valid_d = 1'b1;
            tcnt_d    = '0;
            state_d   = ST_IDLE;
          end
          // A delimiter before any payload is swallowed and leaves the timer alone.
        end else if (!g_valid) begin
          if (tcnt_q != TCNT_MAX) begin
            tcnt_d = tcnt_q + TW'(1);
          end
          if (tmo_hit) begin
            state_d = seen_q ? ST_FLUSH : ST_IDLE;
          end
        end
      end

      ST_FLUSH: begin
        if (slot_free) begin
          m_data_d  = COBS_DELIM;
          m_chan_d  = gnt_q;
          m_last_d  = 1'b1;
          m_valid_d = 1'b1;
          abort_d   = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      seen_q    <= 1'b0;
      tcnt_q    <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_chan_q  <= '0;
      m_last_q  <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      seen_q    <= seen_d;
      tcnt_q    <= tcnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_chan_q  <= m_chan_d;
      m_last_q  <= m_last_d;
      abort_q   <= abort_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_chan  = m_chan_q;
  assign m_last  = m_last_q;
  assign abort   = abort_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cobs_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cobs_rx_arbiter
// Brief   : Randomized self-checking bench with a frame-level reference model.
// Revision: 1.0
// ============================================================================
module tb_cobs_rx_arbiter;
  import cobs_pkg::*;

  localparam int NCH     = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(NCH);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NCH-1:0][DW-1:0] s_data;
  logic [NCH-1:0]         s_valid;
  logic [NCH-1:0]         s_ready;
  logic [DW-1:0]          m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [CW-1:0]          m_chan;
  logic                   m_last;
  logic                   abort;
  logic                   busy;

  cobs_rx_arbiter #(
    .NCH     (NCH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_chan  (m_chan),
    .m_last  (m_last),
    .abort   (abort),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] src_q [NCH][$];
  logic [7:0] exp_q [NCH][$];
  int         order_log [$];
  bit         sstate  [NCH];
  bit         started [NCH];
  bit         hold    [NCH];
  int         low_run [NCH];
  int         gap_pct = 0;
  int         rdy_pct = 100;
  bit         abort_ok = 0;
  int         abort_chan = 0;
  int         abort_cnt = 0;
  int         abort_cyc = 0;
  int         last_acc_cyc = 0;

  bit            exp_pend;
  logic [7:0]    exp_d;
  logic [CW-1:0] exp_c;
  logic          exp_l;
  bit            prev_hold;
  logic [7:0]    prev_d;
  logic [CW-1:0] prev_c;
  logic          prev_l;
  bit            in_frame;
  logic [CW-1:0] cur_chan;

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) begin
      src_q[c].delete();
      exp_q[c].delete();
      sstate[c]  = 0;
      started[c] = 0;
      hold[c]    = 0;
      low_run[c] = 0;
    end
    order_log.delete();
    exp_pend  = 0;
    prev_hold = 0;
    in_frame  = 0;
    abort_cnt = 0;
    s_valid   = '0;
    s_data    = '0;
  endtask

  // Frame rule: leading zeros vanish, payload passes, first zero after payload ends the frame.
  task automatic send(input int c, input logic [7:0] b);
    src_q[c].push_back(b);
    if (b != 8'h00) begin
      exp_q[c].push_back(b);
      sstate[c] = 1;
    end else if (sstate[c]) begin
      exp_q[c].push_back(8'h00);
      sstate[c] = 0;
    end
  endtask

  task automatic step();
    logic [7:0] b;
    logic [7:0] e;
    bit         new_load;
    bit         pend_was;
    @(negedge clk);
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      if (!hold[c]) begin
        if (src_q[c].size() > 0 && (low_run[c] >= 3 || $urandom_range(99) >= gap_pct)) begin
          s_valid[c] = 1'b1;
          s_data[c]  = src_q[c][0];
          low_run[c] = 0;
        end else begin
          s_valid[c] = 1'b0;
          if (src_q[c].size() > 0) low_run[c]++;
        end
      end
    end
    m_ready = ($urandom_range(99) < rdy_pct);
    #1;
    new_load = m_valid && !prev_hold;
    pend_was = exp_pend;
    if (exp_pend) begin
      tests++;
      if (!(m_valid === 1'b1 && m_data === exp_d && m_chan === exp_c && m_last === exp_l)) begin
        fails++;
        $display("FAIL latency cyc=%0d: got v=%0b d=%02h c=%0d l=%0b, want v=1 d=%02h c=%0d l=%0b",
                 cyc, m_valid, m_data, m_chan, m_last, exp_d, exp_c, exp_l);
      end
      exp_pend = 0;
    end else if (new_load && !abort) begin
      tests++;
      fails++;
      $display("FAIL unexpected_out cyc=%0d: got d=%02h c=%0d l=%0b, want no new byte",
               cyc, m_data, m_chan, m_last);
    end
    if (abort) begin
      tests++;
      if (!(abort_ok && new_load && !pend_was && m_data === 8'h00 && m_last === 1'b1 &&
            int'(m_chan) == abort_chan)) begin
        fails++;
        $display("FAIL abort_pulse cyc=%0d: got v=%0b d=%02h c=%0d l=%0b, want allowed abort with 00/last on ch%0d",
                 cyc, m_valid, m_data, m_chan, m_last, abort_chan);
      end else begin
        abort_cnt++;
        abort_cyc = cyc;
      end
    end
    if (prev_hold) begin
      tests++;
      if (!(m_valid === 1'b1 && m_data === prev_d && m_chan === prev_c && m_last === prev_l)) begin
        fails++;
        $display("FAIL hold_stable cyc=%0d: got v=%0b d=%02h c=%0d l=%0b, want v=1 d=%02h c=%0d l=%0b",
                 cyc, m_valid, m_data, m_chan, m_last, prev_d, prev_c, prev_l);
      end
    end
    tests++;
    if ($countones(s_ready) > 1 || (s_ready != '0 && m_valid && !m_ready)) begin
      fails++;
      $display("FAIL s_ready cyc=%0d: got s_ready=%b m_valid=%0b m_ready=%0b, want one-hot-or-zero and low when slot full",
               cyc, s_ready, m_valid, m_ready);
    end
    if (m_valid && m_ready) begin
      tests++;
      if (exp_q[m_chan].size() == 0) begin
        fails++;
        $display("FAIL stream cyc=%0d: got d=%02h on ch%0d, want nothing", cyc, m_data, m_chan);
      end else begin
        e = exp_q[m_chan].pop_front();
        if (e !== m_data) begin
          fails++;
          $display("FAIL stream cyc=%0d ch%0d: got %02h want %02h", cyc, m_chan, m_data, e);
        end
      end
      if (in_frame) begin
        tests++;
        if (m_chan !== cur_chan) begin
          fails++;
          $display("FAIL interleave cyc=%0d: got ch%0d want ch%0d", cyc, m_chan, cur_chan);
        end
      end
      in_frame = !m_last;
      cur_chan = m_chan;
      if (m_last) order_log.push_back(int'(m_chan));
    end
    for (int c = 0; c < NCH; c++) begin
      if (s_valid[c] && s_ready[c]) begin
        b = src_q[c].pop_front();
        hold[c] = 0;
        last_acc_cyc = cyc;
        if (b != 8'h00) begin
          exp_pend = 1; exp_d = b; exp_c = CW'(c); exp_l = 1'b0;
          started[c] = 1;
        end else if (started[c]) begin
          exp_pend = 1; exp_d = 8'h00; exp_c = CW'(c); exp_l = 1'b1;
          started[c] = 0;
        end
      end else begin
        hold[c] = s_valid[c];
      end
    end
    prev_hold = m_valid && !m_ready;
    prev_d    = m_data;
    prev_c    = m_chan;
    prev_l    = m_last;
  endtask

  function automatic bit all_done();
    bit d = !exp_pend && !m_valid;
    for (int c = 0; c < NCH; c++) begin
      if (src_q[c].size() != 0 || exp_q[c].size() != 0) d = 0;
    end
    return d;
  endfunction

  task automatic drain(input int max_cyc, input string name);
    int n = 0;
    while (n < max_cyc && !all_done()) begin
      step();
      n++;
    end
    tests++;
    if (!all_done()) begin
      fails++;
      $display("FAIL drain_%s: got traffic still pending after %0d cycles, want all frames delivered", name, n);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    s_valid = '1;
    s_data  = {8'h11, 8'h22, 8'h33, 8'h44};
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({m_valid, m_last, abort, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got v/l/abort/busy=%b want 0000", {m_valid, m_last, abort, busy});
    end
    tests++;
    if (m_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_m_data: got %02h want 00", m_data);
    end
    tests++;
    if (m_chan !== '0) begin
      fails++;
      $display("FAIL reset_m_chan: got %0d want 0", m_chan);
    end
    tests++;
    if (s_ready !== '0) begin
      fails++;
      $display("FAIL reset_s_ready: got %b want 0000", s_ready);
    end
    s_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] f [6];
    f = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    gap_pct = 0;
    rdy_pct = 100;
    order_log.delete();
    for (int i = 0; i < 6; i++) send(1, f[i]);
    drain(100, "basic");
    tests++;
    if (order_log.size() != 1 || order_log[0] != 1) begin
      fails++;
      $display("FAIL basic_frames: got %0d frames (first ch%0d), want 1 frame on ch1",
               order_log.size(), (order_log.size() > 0) ? order_log[0] : -1);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    gap_pct = 0;
    rdy_pct = 100;
    send(0, 8'h02); send(0, 8'h5a); send(0, 8'h00);
    send(0, 8'h03); send(0, 8'h77); send(0, 8'h00);
    send(2, 8'h04); send(2, 8'hc3); send(2, 8'h19); send(2, 8'h00);
    drain(200, "round_robin");
    tests++;
    if (order_log.size() != 3 || order_log[0] != 0 || order_log[1] != 2 || order_log[2] != 0) begin
      fails++;
      $display("FAIL rr_order: got %0d frames [%0d %0d %0d], want [0 2 0]", order_log.size(),
               (order_log.size() > 0) ? order_log[0] : -1, (order_log.size() > 1) ? order_log[1] : -1,
               (order_log.size() > 2) ? order_log[2] : -1);
    end
  endtask

  task automatic test_stall();
    gap_pct = 0;
    rdy_pct = 50;
    for (int i = 1; i <= 8; i++) send(2, 8'(i * 17));
    send(2, 8'h00);
    drain(300, "stall");
    rdy_pct = 100;
  endtask

  task automatic test_timeout();
    int n = 0;
    gap_pct = 0;
    rdy_pct = 100;
    abort_ok = 1;
    abort_chan = 3;
    abort_cnt = 0;
    order_log.delete();
    send(3, 8'h03);
    send(3, 8'h11);
    exp_q[3].push_back(8'h00);
    sstate[3] = 0;
    while (n < 4 * TIMEOUT && abort_cnt == 0) begin
      step();
      n++;
    end
    tests++;
    if (abort_cnt != 1 || abort_cyc - last_acc_cyc < TIMEOUT + 1 || abort_cyc - last_acc_cyc > TIMEOUT + 3) begin
      fails++;
      $display("FAIL timeout_abort: got %0d aborts, %0d cycles after last byte, want 1 abort after %0d..%0d",
               abort_cnt, abort_cyc - last_acc_cyc, TIMEOUT + 1, TIMEOUT + 3);
    end
    repeat (3) step();
    tests++;
    if (abort_cnt != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_after: got aborts=%0d busy=%0b, want aborts=1 busy=0", abort_cnt, busy);
    end
    tests++;
    if (order_log.size() != 1 || order_log[0] != 3) begin
      fails++;
      $display("FAIL timeout_frame: got %0d terminated frames, want 1 on ch3", order_log.size());
    end
    abort_ok = 0;
    send(0, 8'h02); send(0, 8'h99); send(0, 8'h00);
    drain(100, "after_timeout");
  endtask

  task automatic test_leading_zeros();
    logic [7:0] f [6];
    f = '{8'h00, 8'h00, 8'h03, 8'haa, 8'hbb, 8'h00};
    gap_pct = 0;
    rdy_pct = 100;
    for (int i = 0; i < 6; i++) send(0, f[i]);
    drain(100, "leading_zeros");
    abort_cnt = 0;
    send(1, 8'h00);
    send(1, 8'h00);
    repeat (TIMEOUT + 8) step();
    tests++;
    if (abort_cnt != 0 || busy !== 1'b0 || src_q[1].size() != 0) begin
      fails++;
      $display("FAIL silent_timeout: got aborts=%0d busy=%0b left=%0d, want 0/0/0",
               abort_cnt, busy, src_q[1].size());
    end
  endtask

  task automatic test_random();
    int nz;
    int len;
    gap_pct = 30;
    rdy_pct = 70;
    order_log.delete();
    for (int f = 0; f < 40; f++) begin
      int c = $urandom_range(NCH - 1);
      nz  = $urandom_range(2);
      len = $urandom_range(6, 1);
      for (int i = 0; i < nz; i++) send(c, 8'h00);
      for (int i = 0; i < len; i++) send(c, 8'($urandom_range(255, 1)));
      send(c, 8'h00);
    end
    drain(5000, "random");
    tests++;
    if (order_log.size() != 40) begin
      fails++;
      $display("FAIL random_frames: got %0d frames want 40", order_log.size());
    end
    gap_pct = 0;
    rdy_pct = 100;
  endtask

  task automatic test_reset_midframe();
    gap_pct = 0;
    rdy_pct = 100;
    for (int i = 1; i <= 9; i++) send(2, 8'(i));
    send(2, 8'h00);
    repeat (5) step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({m_valid, m_last, abort, busy} !== 4'b0000 || m_data !== 8'h00 || m_chan !== '0 || s_ready !== '0) begin
      fails++;
      $display("FAIL async_reset: got v=%0b l=%0b abort=%0b busy=%0b d=%02h c=%0d rdy=%b, want all 0",
               m_valid, m_last, abort, busy, m_data, m_chan, s_ready);
    end
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(3, 8'h05); send(3, 8'h06); send(3, 8'h00);
    send(0, 8'h07); send(0, 8'h08); send(0, 8'h00);
    drain(100, "post_reset");
    tests++;
    if (order_log.size() != 2 || order_log[0] != 0 || order_log[1] != 3) begin
      fails++;
      $display("FAIL post_reset_order: got %0d frames first ch%0d, want [0 3]", order_log.size(),
               (order_log.size() > 0) ? order_log[0] : -1);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    m_ready = 1'b0;
    clear_model();
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_timeout();
    test_leading_zeros();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by cycle %0d, want bench to finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
